// File: rtl/sdffe_sched_pkg.sv
`default_nettype none
// ============================================================================
// sdffe_sched_pkg : shared types/constants for the SDFFE round-robin scheduler
// Rev 1.0
// ============================================================================
package sdffe_sched_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam int NREQ_DEFAULT  = 4;
   localparam int WIDTH_DEFAULT = 2;
   localparam int MAX_NREQ      = 16;

   function automatic logic [MAX_NREQ-1:0] onehot(input logic [3:0] idx);
      return MAX_NREQ'(1) << idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sdffe_rr_scheduler_rr_pick.sv
`default_nettype none
// ============================================================================
// rr_pick : combinational round-robin picker, first set request at or after ptr
// Rev 1.0
// ============================================================================
module rr_pick #(
   parameter  int NREQ = 4,
   localparam int PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [PW-1:0]   win,
   output logic            valid
);

   localparam int SW = PW + 1;

   // One spare bit so ptr+k never overflows before the modulo fold
   logic [SW-1:0] sum;

   always_comb begin
      win   = '0;
      valid = 1'b0;
      sum   = '0;
      for (int k = 0; k < NREQ; k++) begin
         sum = {1'b0, ptr} + SW'(k);
         if (sum >= SW'(NREQ)) begin
            sum = sum - SW'(NREQ);
         end
         if (!valid && req[sum[PW-1:0]]) begin
            valid = 1'b1;
            win   = sum[PW-1:0];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/sdffe_rr_scheduler.sv
`default_nettype none
// ============================================================================
// sdffe_rr_scheduler : round-robin load/clear scheduler for one shared SDFFE
// Rev 1.0
// ============================================================================
module sdffe_rr_scheduler
   import sdffe_sched_pkg::*;
#(
   parameter  int NREQ  = NREQ_DEFAULT,
   parameter  int WIDTH = WIDTH_DEFAULT,
   localparam int PW    = $clog2(NREQ)
) (
   input  logic                  CLK,
   input  logic                  ARST_N,
   input  logic [NREQ-1:0]       REQ,
   input  logic [NREQ-1:0]       CLR,
   input  logic [NREQ*WIDTH-1:0] DATA,
   input  logic                  FREEZE,
   output logic [NREQ-1:0]       GNT,
   output logic                  FF_EN,
   output logic                  FF_SRST,
   output logic [WIDTH-1:0]      FF_D,
   output logic                  BUSY
);

   state_t           state;
   logic [PW-1:0]    ptr;
   logic [PW-1:0]    win;
   logic             win_valid;
   logic             sel_clr;
   logic [WIDTH-1:0] sel_data;
   logic [PW-1:0]    next_ptr;

   rr_pick #(
      .NREQ (NREQ)
   ) u_pick (
      .req   (REQ),
      .ptr   (ptr),
      .win   (win),
      .valid (win_valid)
   );

   always_comb begin
      sel_clr  = 1'b0;
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win == PW'(i)) begin
            sel_clr  = CLR[i];
            sel_data = DATA[i*WIDTH +: WIDTH];
         end
      end
      next_ptr = (win == PW'(NREQ-1)) ? '0 : win + PW'(1);
   end

   // Outputs default to zero every edge; only an IDLE grant raises them for one cycle
   always_ff @(posedge CLK or negedge ARST_N) begin
      if (!ARST_N) begin
         state   <= IDLE;
         ptr     <= '0;
         GNT     <= '0;
         FF_EN   <= 1'b0;
         FF_SRST <= 1'b0;
         FF_D    <= '0;
         BUSY    <= 1'b0;
      end else begin
         state   <= IDLE;
         GNT     <= '0;
         FF_EN   <= 1'b0;
         FF_SRST <= 1'b0;
         FF_D    <= '0;
         BUSY    <= 1'b0;
         case (state)
            IDLE: begin
               if (!FREEZE && win_valid) begin
                  state   <= GRANT;
                  GNT     <= NREQ'(onehot(4'(win)));
                  FF_EN   <= 1'b1;
                  FF_SRST <= sel_clr;
                  FF_D    <= sel_clr ? '0 : sel_data;
                  BUSY    <= 1'b1;
                  ptr     <= next_ptr;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sdffe_rr_scheduler.sv
`default_nettype none
// ============================================================================
// tb_sdffe_rr_scheduler : directed self-checking bench with a behavioural SDFFE
// Rev 1.0
// ============================================================================
module tb_sdffe_rr_scheduler;

   logic       clk;
   logic       arst_n;
   logic [3:0] req;
   logic [3:0] clr;
   logic [7:0] data;
   logic       freeze;
   logic [3:0] gnt;
   logic       ff_en;
   logic       ff_srst;
   logic [1:0] ff_d;
   logic       busy;
   logic [1:0] q;

   int errors = 0;
   int checks = 0;

   sdffe_rr_scheduler #(
      .NREQ  (4),
      .WIDTH (2)
   ) dut (
      .CLK     (clk),
      .ARST_N  (arst_n),
      .REQ     (req),
      .CLR     (clr),
      .DATA    (data),
      .FREEZE  (freeze),
      .GNT     (gnt),
      .FF_EN   (ff_en),
      .FF_SRST (ff_srst),
      .FF_D    (ff_d),
      .BUSY    (busy)
   );

   // Shared SDFFE cell outside the scheduler, SRST wins over EN
   initial q = 2'b00;
   always_ff @(posedge clk) begin
      if (ff_srst)    q <= 2'b00;
      else if (ff_en) q <= ff_d;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_outs(input string tag, input logic [3:0] g, input logic en,
                             input logic sr, input logic [1:0] d, input logic b);
      check_val({tag, ".gnt"},  32'(gnt),     32'(g));
      check_val({tag, ".en"},   32'(ff_en),   32'(en));
      check_val({tag, ".srst"}, 32'(ff_srst), 32'(sr));
      check_val({tag, ".d"},    32'(ff_d),    32'(d));
      check_val({tag, ".busy"}, 32'(busy),    32'(b));
   endtask

   initial begin
      logic [3:0] seq [5];
      seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      arst_n = 1'b1;
      req    = '0;
      clr    = '0;
      data   = '0;
      freeze = 1'b0;

      // Reset values
      #2 arst_n = 1'b0;
      #1 check_outs("reset", 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0);
      @(negedge clk);
      arst_n = 1'b1;

      // Continuous requests from ptr=0: 0,1,2,3,0 every other cycle; data[i]=i
      req  = 4'b1111;
      data = {2'b11, 2'b10, 2'b01, 2'b00};
      for (int c = 0; c < 10; c++) begin
         tick();
         if (c % 2 == 0) begin
            check_outs($sformatf("rr%0d", c), seq[c/2], 1'b1, 1'b0, 2'(c/2 % 4), 1'b1);
         end else begin
            check_outs($sformatf("rr%0d", c), 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0);
            check_val($sformatf("rr%0d.q", c), 32'(q), 32'((c/2) % 4));
         end
      end
      req = '0;

      // Single load from requester 2 (ptr=1)
      data = 8'b00_10_00_00;
      req  = 4'b0100;
      tick();
      check_outs("load", 4'b0100, 1'b1, 1'b0, 2'b10, 1'b1);
      req = '0;
      tick();
      check_outs("load_end", 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0);
      check_val("load.q", 32'(q), 32'h2);

      // Clear from requester 1 ignores its data (ptr=3, wraps to 1)
      req  = 4'b0010;
      clr  = 4'b0010;
      data = 8'b00_00_11_00;
      tick();
      check_outs("clear", 4'b0010, 1'b1, 1'b1, 2'b00, 1'b1);
      req = '0;
      clr = '0;
      tick();
      check_val("clear.q", 32'(q), 32'h0);

      // Move ptr to 3, then wrap: 3 before 0, ptr ends at 1
      req = 4'b0100;
      tick();
      check_val("wrap.pre", 32'(gnt), 32'h4);
      req = 4'b1001;
      tick();
      tick();
      check_val("wrap.first", 32'(gnt), 32'h8);
      tick();
      tick();
      check_val("wrap.second", 32'(gnt), 32'h1);
      req = 4'b1111;
      tick();
      tick();
      check_val("wrap.ptr1", 32'(gnt), 32'h2);
      req = '0;
      tick();

      // Freeze holds off grants; release grants next cycle (ptr=2 -> 0)
      freeze = 1'b1;
      req    = 4'b0001;
      for (int c = 0; c < 5; c++) begin
         tick();
         check_val($sformatf("frz%0d.gnt", c), 32'(gnt), 32'h0);
         check_val($sformatf("frz%0d.en", c), 32'(ff_en), 32'h0);
      end
      freeze = 1'b0;
      tick();
      check_val("unfreeze.gnt", 32'(gnt), 32'h1);
      req = '0;
      tick();

      // Freeze raised during GRANT does not cancel the op
      req  = 4'b0100;
      data = 8'b00_01_00_00;
      tick();
      check_val("frzgrant.gnt", 32'(gnt), 32'h4);
      freeze = 1'b1;
      req    = '0;
      tick();
      check_val("frzgrant.q", 32'(q), 32'h1);
      freeze = 1'b0;

      // Async reset mid-GRANT, then fresh round-robin from 0 (ptr=3 -> 1)
      req = 4'b0010;
      tick();
      check_val("rst.pre", 32'(gnt), 32'h2);
      #2 arst_n = 1'b0;
      #1 check_outs("rst.mid", 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0);
      #2 arst_n = 1'b1;
      req = 4'b1111;
      tick();
      check_val("rst.post", 32'(gnt), 32'h1);
      check_val("rst.q", 32'(q), 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
